// File: rtl/shape_pattern_streamer.sv
// shape_pattern_streamer
//   Procedural test-frame source for the shape detector. Each trigger produces
//   one raster-order 8-bit greyscale frame. The frame holds a circle, a square,
//   a triangle, or LFSR noise. Every output is registered.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   start        level trigger; launches a frame when armed (armed by start=0 in IDLE)
//   image_select 00 circle, 01 square, 10 triangle, 11 LFSR noise (latched at launch)
//   pixel_data   pixel value, valid with pixel_valid
//   pixel_valid  one pixel per asserted cycle
//   frame_start  1-cycle pulse with pixel (0,0)
//   frame_done   1-cycle pulse the cycle after the last pixel
//   busy         high from launch through the frame_done cycle
module shape_pattern_streamer #(
  parameter int         IMG_W   = 64,
  parameter int         IMG_H   = 64,
  parameter int         PIX_GAP = 0,
  parameter int         CIRC_R  = 20,
  parameter int         HALF    = 16,
  parameter logic [7:0] FG      = 8'hFF,
  parameter logic [7:0] BG      = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] image_select,
  output logic [7:0] pixel_data,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy
);

  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int DW   = $clog2(MAXD) + 2;
  // Geometry arithmetic width covers both the squared offsets and the
  // squared radius, so a large CIRC_R on a small frame cannot wrap.
  localparam int RW   = $clog2(CIRC_R * CIRC_R + 1) + 2;
  localparam int HW   = $clog2(HALF + 1) + 3;
  localparam int SW0  = (2 * DW > RW) ? 2 * DW : RW;
  localparam int SW   = (SW0 > HW) ? SW0 : HW;

  localparam logic [XW-1:0]        X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]        Y_LAST    = YW'(IMG_H - 1);
  localparam logic signed [SW-1:0] CX        = SW'(IMG_W / 2);
  localparam logic signed [SW-1:0] CY        = SW'(IMG_H / 2);
  localparam logic signed [SW-1:0] R2        = SW'(CIRC_R * CIRC_R);
  localparam logic signed [SW-1:0] HALF_S    = SW'(HALF);
  localparam logic [3:0]           GAP_LAST  = 4'((PIX_GAP > 0) ? PIX_GAP - 1 : 0);
  localparam logic [15:0]          LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

  state_t        state, state_n;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0]    gap_cnt;
  logic          armed;
  logic [1:0]    sel_q;
  logic [15:0]   lfsr;

  logic launch, last_pix;
  logic valid_n, fstart_n, done_n, busy_n;

  // Next-state and next-output logic; the output registers sit one cycle
  // behind the state, so pixel (0,0) appears the cycle after entering STREAM.
  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    valid_n  = 1'b0;
    fstart_n = 1'b0;
    done_n   = 1'b0;
    busy_n   = 1'b0;
    last_pix = (x == X_LAST) && (y == Y_LAST);
    case (state)
      IDLE: begin
        if (start && armed) begin
          launch  = 1'b1;
          busy_n  = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        valid_n  = 1'b1;
        busy_n   = 1'b1;
        fstart_n = (x == '0) && (y == '0);
        if (last_pix)         state_n = DONE;
        else if (PIX_GAP > 0) state_n = GAP;
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt == GAP_LAST) state_n = STREAM;
      end
      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Pixel function of (sel_q, x, y)
  logic signed [SW-1:0] dx, dy, adx, ady, dist2;
  logic                 pix_hit;
  logic [7:0]           pix;

  always_comb begin
    dx      = $signed(SW'(x)) - CX;
    dy      = $signed(SW'(y)) - CY;
    adx     = dx[SW-1] ? -dx : dx;
    ady     = dy[SW-1] ? -dy : dy;
    dist2   = dx * dx + dy * dy;
    pix_hit = 1'b0;
    case (sel_q)
      2'b00:   pix_hit = (dist2 <= R2);
      2'b01:   pix_hit = (adx <= HALF_S) && (ady <= HALF_S);
      2'b10:   pix_hit = (dy >= -HALF_S) && (dy <= HALF_S) && ((adx + adx) <= (dy + HALF_S));
      default: pix_hit = lfsr[0];
    endcase
    pix = pix_hit ? FG : BG;
  end

  logic lfsr_fb;
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      gap_cnt     <= '0;
      armed       <= 1'b0;
      sel_q       <= '0;
      lfsr        <= LFSR_SEED;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pixel_valid <= valid_n;
      frame_start <= fstart_n;
      frame_done  <= done_n;
      busy        <= busy_n;
      if (valid_n) pixel_data <= pix;

      if (state == IDLE) begin
        if (launch)     armed <= 1'b0;
        else if (!start) armed <= 1'b1;
      end

      if (launch) begin
        sel_q   <= image_select;
        x       <= '0;
        y       <= '0;
        gap_cnt <= '0;
        lfsr    <= LFSR_SEED;
      end else if (state == STREAM) begin
        lfsr    <= {lfsr_fb, lfsr[15:1]};
        gap_cnt <= '0;
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shape_pattern_streamer.sv
// tb_shape_pattern_streamer
//   Directed bench for shape_pattern_streamer. One default 64x64 instance is
//   used for the shape, noise, retrigger and reset cases. A 4x4 instance with
//   PIX_GAP=2 and HALF=1 is used for gap timing.
module tb_shape_pattern_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start_s;
  logic [1:0] sel, sel_s;
  logic [7:0] pd, pd_s;
  logic       pv, fs, fd, bz;
  logic       pv_s, fs_s, fd_s, bz_s;

  shape_pattern_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .image_select(sel),
    .pixel_data(pd), .pixel_valid(pv), .frame_start(fs), .frame_done(fd), .busy(bz)
  );

  shape_pattern_streamer #(.IMG_W(4), .IMG_H(4), .PIX_GAP(2), .HALF(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .image_select(sel_s),
    .pixel_data(pd_s), .pixel_valid(pv_s), .frame_start(fs_s), .frame_done(fd_s), .busy(bz_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] fb     [0:4095];
  logic [7:0] ref_fb [0:4095];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise start (must already be armed) and check the two-edge launch latency.
  task automatic launch(input logic [1:0] s, input bit hold);
    start = 1'b1;
    sel   = s;
    tick();
    check("lat_busy", 32'(bz), 32'd1);
    check("lat_early_fs", 32'(fs), 32'd0);
    if (!hold) start = 1'b0;
    tick();
    check("lat_fs", 32'(fs), 32'd1);
    check("lat_fs_valid", 32'(pv), 32'd1);
  endtask

  // Called at the frame_start cycle; returns at the frame_done cycle.
  task automatic capture(output int nv, output int dc);
    int c;
    c  = 0;
    nv = 0;
    dc = -1;
    while (c < 5000) begin
      if (pv) begin
        if (nv < 4096) fb[nv] = pd;
        nv++;
      end
      if (fd) begin
        dc = c;
        break;
      end
      tick();
      c++;
    end
    if (dc < 0) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv, dc, cnt, c, pat_err, pix_err, bad;
    logic [7:0] last, exp_px;
    logic [5:0] bits;

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; sel = 2'b00; sel_s = 2'b00;
    repeat (3) tick();
    check("rst_valid", 32'(pv), 32'd0);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_done", 32'(fd), 32'd0);
    check("rst_data", 32'(pd), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: circle
    launch(2'b00, 1'b0);
    capture(nv, dc);
    check("circ_nvalid", nv, 4096);
    check("circ_done_cyc", dc, 4096);
    check("circ_32_12", 32'(fb[12*64+32]), 32'hFF);
    check("circ_32_11", 32'(fb[11*64+32]), 32'h00);
    check("circ_12_32", 32'(fb[32*64+12]), 32'hFF);
    check("circ_0_0", 32'(fb[0]), 32'h00);
    tick();
    check("circ_busy_after", 32'(bz), 32'd0);

    // 2: square
    launch(2'b01, 1'b0);
    capture(nv, dc);
    check("sq_16_16", 32'(fb[16*64+16]), 32'hFF);
    check("sq_15_16", 32'(fb[16*64+15]), 32'h00);
    check("sq_48_48", 32'(fb[48*64+48]), 32'hFF);
    check("sq_49_48", 32'(fb[48*64+49]), 32'h00);
    cnt = 0;
    for (int i = 0; i < 4096; i++) if (fb[i] == 8'hFF) cnt++;
    check("sq_ff_count", cnt, 1089);
    tick();

    // 3: triangle
    launch(2'b10, 1'b0);
    capture(nv, dc);
    check("tri_apex", 32'(fb[16*64+32]), 32'hFF);
    check("tri_apex_r", 32'(fb[16*64+33]), 32'h00);
    check("tri_base", 32'(fb[48*64+16]), 32'hFF);
    check("tri_base_l", 32'(fb[48*64+15]), 32'h00);
    cnt = 0;
    for (int i = 0; i < 64; i++) if (fb[49*64+i] != 8'h00) cnt++;
    check("tri_row49", cnt, 0);
    tick();

    // 4: 4x4 with two idle cycles per pixel, HALF=1 square
    start_s = 1'b1; sel_s = 2'b01;
    tick();
    start_s = 1'b0;
    tick();
    check("s_fs", 32'(fs_s), 32'd1);
    c = 0; nv = 0; dc = -1; pat_err = 0; pix_err = 0; last = 8'h00;
    while (c < 200) begin
      if (pv_s !== ((c % 3 == 0) && (c <= 45))) pat_err++;
      if (pv_s) begin
        exp_px = ((nv % 4 >= 1) && (nv / 4 >= 1)) ? 8'hFF : 8'h00;
        if (pd_s !== exp_px) pix_err++;
        last = pd_s;
        nv++;
      end else if (c < 46 && pd_s !== last) begin
        pix_err++;
      end
      if (fd_s) begin
        dc = c;
        break;
      end
      tick();
      c++;
    end
    check("s_nvalid", nv, 16);
    check("s_done_cyc", dc, 46);
    check("s_gap_pattern", pat_err, 0);
    check("s_pixels_hold", pix_err, 0);
    tick();
    check("s_busy_after", 32'(bz_s), 32'd0);

    // 5: noise with start held through frame_done, then retrigger
    launch(2'b11, 1'b1);
    capture(nv, dc);
    check("noise_nvalid", nv, 4096);
    for (int i = 0; i < 6; i++) bits[i] = (fb[i] == 8'hFF);
    check("noise_first6", 32'(bits), 32'b100001);
    for (int i = 0; i < 4096; i++) ref_fb[i] = fb[i];
    bad = 0;
    repeat (20) begin
      tick();
      if (pv || bz || fs) bad++;
    end
    check("no_relaunch", bad, 0);
    start = 1'b0;
    tick();
    launch(2'b11, 1'b0);
    sel = 2'b00;
    capture(nv, dc);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (fb[i] !== ref_fb[i]) bad++;
    check("noise_repeat", bad, 0);
    tick();

    // 6: reset at pixel 100
    launch(2'b00, 1'b0);
    repeat (100) tick();
    check("pre_rst_valid", 32'(pv), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(pv), 32'd0);
    check("mid_rst_busy", 32'(bz), 32'd0);
    check("mid_rst_data", 32'(pd), 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    bad = 0;
    repeat (30) begin
      tick();
      if (pv || bz || fd) bad++;
    end
    check("post_rst_quiet", bad, 0);
    start = 1'b0;
    tick();
    launch(2'b00, 1'b0);
    capture(nv, dc);
    check("post_rst_nvalid", nv, 4096);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shape_pattern_streamer.md
Name: shape_pattern_streamer

Overview:
Upstream pixel source for the shape detector. Once per trigger it generates one raster-order 8-bit greyscale frame containing a procedurally drawn circle, square, triangle or pseudo-random noise field. It drives pixel_data/pixel_valid with frame_start/frame_done markers, in the form the detector datapath consumes. It needs no ROM, so test frames are parameter-scalable and deterministic.

Parameters:
IMG_W, 64, frame width in pixels (4..1024)
IMG_H, 64, frame height in pixels (4..1024)
PIX_GAP, 0, idle cycles inserted after each pixel except the last (0..15)
CIRC_R, 20, circle radius in pixels
HALF, 16, half side of square; half height of triangle
FG, 8'hFF, foreground pixel value
BG, 8'h00, background pixel value

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  level trigger; launches a frame when armed
image_select  in  2  00 circle, 01 square, 10 triangle, 11 LFSR noise
pixel_data  out  8  pixel value, valid when pixel_valid=1
pixel_valid  out  1  one pixel per asserted cycle
frame_start  out  1  1-cycle pulse coincident with pixel (0,0)
frame_done  out  1  1-cycle pulse the cycle after the last pixel
busy  out  1  high from launch through the frame_done cycle

Behaviour:
- Reset (rst_n=0 sampled at posedge): state=IDLE. All outputs are 0 (pixel_data=8'h00). x=y=gap_cnt=0, armed=0. Reset mid-frame aborts immediately, with outputs 0 after that edge.
- Arming: armed is set on any edge with start=0 in IDLE and cleared at launch. This gives one frame per trigger, so start held high through frame_done does not relaunch.
- States: IDLE -> STREAM -> (GAP <-> STREAM) -> DONE -> IDLE.
- IDLE: if start=1 and armed=1, latch image_select into sel_q, set x=y=0, seed the LFSR to 16'hACE1, and go to STREAM.
- Launch latency: the start sample edge is edge k. Pixel (0,0) is driven in the cycle after edge k+1. All outputs are registered.
- STREAM: pixel_valid=1 and pixel_data=f(sel_q,x,y). frame_start=1 only for (0,0). x increments; at x=IMG_W-1, x wraps to 0 and y increments. After the pixel at (IMG_W-1, IMG_H-1), go to DONE. Otherwise go to GAP if PIX_GAP>0, else stay in STREAM.
- GAP: pixel_valid=0 and pixel_data holds its last value. Stay for exactly PIX_GAP cycles, then return to STREAM.
- DONE: frame_done=1 and busy=1 for one cycle, pixel_valid=0, then IDLE.
- Frame length: IMG_W*IMG_H pixels. Cycles from first pixel to frame_done = IMG_W*IMG_H*(1+PIX_GAP) - PIX_GAP.
- Geometry:
  - cx=IMG_W/2, cy=IMG_H/2 (integer division).
  - dx=x-cx and dy=y-cy are signed, clog2(max(W,H))+2 bits.
  - Squares are computed at double width; no overflow is allowed within the parameter range.
- Shape rules (FG if the condition holds, else BG):
  - Circle: dx*dx + dy*dy <= CIRC_R*CIRC_R (boundary inclusive).
  - Square: |dx|<=HALF and |dy|<=HALF.
  - Triangle (apex up, base at dy=+HALF): -HALF<=dy<=HALF and 2*|dx| <= dy+HALF.
  - Noise: 16-bit Fibonacci LFSR, taps 16,14,13,11, advanced once per emitted pixel. Pixel = FG if lfsr[0]=1, else BG. The LFSR is reseeded at each launch.
- Combinational pixel math may be registered one stage internally. The externally visible timing above is mandatory.
- image_select changes mid-frame are ignored (sel_q is used). Deasserting start mid-frame does not abort the frame.
- Simultaneous events: rst_n=0 overrides everything. start=1 in DONE is ignored (armed=0).

Test Plan:
1. Reset, then start=1 one cycle with select=00 (defaults) -> frame_start with the first pixel_valid. Pixel (32,12)=FF, (32,11)=00, (12,32)=FF. Exactly 4096 valids, frame_done 4096 cycles after frame_start, busy low the cycle after.
2. Select=01 -> (16,16)=FF, (15,16)=00, (48,48)=FF, (49,48)=00. Pixel count of FF = 33*33 = 1089.
3. Select=10 -> apex (32,16)=FF, (33,16)=00, base (16,48)=FF, (15,48)=00. Row 49 is all 00.
4. IMG_W=IMG_H=4, PIX_GAP=2 -> 16 valids, each followed by 2 idle cycles except the last. frame_done 46 cycles after frame_start.
5. start held high across frame_done -> no second frame. Drop start for 1 cycle, raise it -> new frame. Select=11 twice -> identical pixel sequences, first pixel = FF (seed LSB=1).
6. rst_n=0 at pixel 100 of a frame -> next edge: pixel_valid/busy/frame_done=0, no frame_done ever. start must go low then high before a new frame launches.
